// File: rtl/tile_sequencer_pkg.sv
// Shared definitions for the tile sequencer: instruction-word bit map, FSM states, idle word.
package tile_sequencer_pkg;

  localparam int unsigned InstW           = 34;
  localparam int unsigned InstKerLd       = 0;
  localparam int unsigned InstExec        = 1;
  localparam int unsigned InstL0Wr        = 2;
  localparam int unsigned InstL0Rd        = 3;
  localparam int unsigned InstOfifoRd     = 6;
  localparam int unsigned InstActAddrLsb  = 7;
  localparam int unsigned InstActCen      = 18;
  localparam int unsigned InstActWen      = 19;
  localparam int unsigned InstPsumAddrLsb = 20;
  localparam int unsigned InstPsumCen     = 31;
  localparam int unsigned InstPsumWen     = 32;
  localparam int unsigned InstAcc         = 33;

  // Both SRAMs deselected (active-low CEN/WEN high), everything else off.
  localparam logic [InstW-1:0] IdleWord = (InstW'(1) << InstActCen)  |
                                          (InstW'(1) << InstActWen)  |
                                          (InstW'(1) << InstPsumCen) |
                                          (InstW'(1) << InstPsumWen);

  typedef enum logic [2:0] {
    StIdle,
    StWRd,
    StWKer,
    StWFlush,
    StPLoad,
    StXRd,
    StXExec,
    StDrain
  } state_e;

endpackage

// File: rtl/tile_sequencer_if.sv
// Host-side handshake and corelet instruction bundle of the tile sequencer.
interface tile_sequencer_if #(
  parameter int unsigned CntBw = 8
);
  import tile_sequencer_pkg::*;

  logic             start;
  logic [CntBw-1:0] num_x;
  logic             acc_en;
  logic             ofifo_valid;
  logic [InstW-1:0] inst;
  logic             psum_ready;
  logic             sfp_reset;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, num_x, acc_en, ofifo_valid,
    input  inst, psum_ready, sfp_reset, busy, done, err
  );

  modport slave (
    input  start, num_x, acc_en, ofifo_valid,
    output inst, psum_ready, sfp_reset, busy, done, err
  );

endinterface

// File: rtl/tile_sequencer_seq_counter.sv
// Loadable up-counter with a terminal-count compare, shared by every sequencer phase.
module seq_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic [Width-1:0] tc_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/tile_sequencer.sv
// Tile sequencer: walks weight load, kernel load, flush, optional psum preload, execute and drain.
module tile_sequencer
  import tile_sequencer_pkg::*;
#(
  parameter int unsigned Row    = 8,
  parameter int unsigned Col    = 8,
  parameter int unsigned AddrBw = 11,
  parameter int unsigned CntBw  = 8
) (
  input logic            clk,
  input logic            reset,
  tile_sequencer_if.slave bus
);

  state_e           state_q;
  logic [InstW-1:0] inst_q;
  logic             psum_ready_q, done_q, err_q, busy_q, sfp_reset_q;
  logic [CntBw-1:0] num_x_q;
  logic             acc_en_q;
  logic             pend_q;
  logic [CntBw-1:0] pend_addr_q;

  logic [CntBw-1:0] ph_cnt, ph_tc_val, out_cnt;
  logic             ph_tc, ph_clr, out_tc, out_en, start_ok;

  assign start_ok = (bus.num_x != '0) && (!bus.acc_en || (bus.num_x <= CntBw'(Row)));

  always_comb begin
    ph_tc_val = '0;
    case (state_q)
      StWRd:    ph_tc_val = CntBw'(Col);
      StWKer:   ph_tc_val = CntBw'(Col - 1);
      StWFlush: ph_tc_val = CntBw'(Row + Col - 1);
      StPLoad:  ph_tc_val = CntBw'(Row);
      StXRd:    ph_tc_val = num_x_q;
      StXExec:  ph_tc_val = num_x_q - CntBw'(1);
      default:  ph_tc_val = '0;
    endcase
  end

  // Phase counter restarts whenever its phase ends, so every state begins at zero.
  assign ph_clr = (state_q == StIdle) || (state_q == StDrain) || ph_tc;
  assign out_en = (state_q == StDrain) && bus.ofifo_valid && !out_tc;

  seq_counter #(.Width(CntBw)) u_ph_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ph_clr),
    .load_val_i('0),
    .en_i      (1'b1),
    .tc_val_i  (ph_tc_val),
    .cnt_o     (ph_cnt),
    .tc_o      (ph_tc)
  );

  seq_counter #(.Width(CntBw)) u_out_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (state_q != StDrain),
    .load_val_i('0),
    .en_i      (out_en),
    .tc_val_i  (num_x_q),
    .cnt_o     (out_cnt),
    .tc_o      (out_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      inst_q       <= IdleWord;
      psum_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      sfp_reset_q  <= 1'b1;
      num_x_q      <= '0;
      acc_en_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      inst_q       <= IdleWord;
      psum_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      busy_q       <= (state_q != StIdle);
      sfp_reset_q  <= (state_q == StIdle);
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (start_ok) begin
              num_x_q  <= bus.num_x;
              acc_en_q <= bus.acc_en;
              state_q  <= StWRd;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // SRAM has one cycle of read latency, so L0 write trails the read by a cycle.
        StWRd: begin
          if (ph_cnt < CntBw'(Col)) begin
            inst_q[InstActCen]                   <= 1'b0;
            inst_q[InstActAddrLsb +: AddrBw]     <= AddrBw'(ph_cnt);
          end
          if (ph_cnt != '0) inst_q[InstL0Wr] <= 1'b1;
          if (ph_tc) state_q <= StWKer;
        end
        StWKer: begin
          inst_q[InstL0Rd]  <= 1'b1;
          inst_q[InstKerLd] <= 1'b1;
          if (ph_tc) state_q <= StWFlush;
        end
        StWFlush: begin
          if (ph_tc) state_q <= acc_en_q ? StPLoad : StXRd;
        end
        StPLoad: begin
          if (ph_cnt == '0) begin
            psum_ready_q <= 1'b1;
          end else begin
            inst_q[InstPsumCen]               <= 1'b0;
            inst_q[InstPsumAddrLsb +: AddrBw] <= AddrBw'(ph_cnt - CntBw'(1));
          end
          if (ph_tc) state_q <= StXRd;
        end
        StXRd: begin
          if (ph_cnt < num_x_q) begin
            inst_q[InstActCen]               <= 1'b0;
            inst_q[InstActAddrLsb +: AddrBw] <= AddrBw'(Col) + AddrBw'(ph_cnt);
          end
          if (ph_cnt != '0) inst_q[InstL0Wr] <= 1'b1;
          if (ph_tc) state_q <= StXExec;
        end
        StXExec: begin
          inst_q[InstL0Rd] <= 1'b1;
          inst_q[InstExec] <= 1'b1;
          inst_q[InstAcc]  <= acc_en_q;
          if (ph_tc) state_q <= StDrain;
        end
        StDrain: begin
          if (out_en) begin
            inst_q[InstOfifoRd] <= 1'b1;
            pend_q              <= 1'b1;
            pend_addr_q         <= out_cnt;
          end
          if (pend_q) begin
            inst_q[InstPsumCen]               <= 1'b0;
            inst_q[InstPsumWen]               <= 1'b0;
            inst_q[InstPsumAddrLsb +: AddrBw] <= AddrBw'(pend_addr_q);
            if (pend_addr_q == num_x_q - CntBw'(1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inst       = inst_q;
  assign bus.psum_ready = psum_ready_q;
  assign bus.sfp_reset  = sfp_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench: per-tile expected instruction stream plus an event model of the drain.
module tb_tile_sequencer;

  localparam int Row = 8;
  localparam int Col = 8;
  localparam logic [33:0] IdleW = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_sequencer_if #(.CntBw(8)) bus ();

  tile_sequencer #(.Row(Row), .Col(Col), .AddrBw(11), .CntBw(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {psum_ready, inst} for every cycle from the first weight read to the last execute.
  task automatic build_exp(input int n, input bit acc);
    logic [33:0] w;
    exp_q.delete();
    for (int k = 0; k <= Col; k++) begin
      w = IdleW;
      if (k < Col) begin w[18] = 1'b0; w[17:7] = 11'(k); end
      if (k > 0) w[2] = 1'b1;
      exp_q.push_back({1'b0, w});
    end
    for (int k = 0; k < Col; k++) begin
      w = IdleW; w[3] = 1'b1; w[0] = 1'b1;
      exp_q.push_back({1'b0, w});
    end
    for (int k = 0; k < Row + Col; k++) exp_q.push_back({1'b0, IdleW});
    if (acc) begin
      exp_q.push_back({1'b1, IdleW});
      for (int k = 0; k < Row; k++) begin
        w = IdleW; w[31] = 1'b0; w[30:20] = 11'(k);
        exp_q.push_back({1'b0, w});
      end
    end
    for (int k = 0; k <= n; k++) begin
      w = IdleW;
      if (k < n) begin w[18] = 1'b0; w[17:7] = 11'(Col + k); end
      if (k > 0) w[2] = 1'b1;
      exp_q.push_back({1'b0, w});
    end
    for (int k = 0; k < n; k++) begin
      w = IdleW; w[3] = 1'b1; w[1] = 1'b1; w[33] = acc;
      exp_q.push_back({1'b0, w});
    end
  endtask

  task automatic abort_reset();
    bus.start = 1'b1; bus.num_x = 8'd3; bus.acc_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; bus.start = 1'b0;
    chk("abort_idle", 64'({bus.busy, bus.done, bus.psum_ready, bus.sfp_reset, bus.inst}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, IdleW}));
    repeat (3) begin
      step();
      chk("abort_quiet", 64'({bus.busy, bus.inst}), 64'({1'b0, IdleW}));
    end
  endtask

  task automatic reject(input int n, input bit acc);
    bus.num_x = 8'(n); bus.acc_en = acc; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rej_err", 64'({bus.err, bus.busy}), 64'({1'b1, 1'b0}));
    step();
    chk("rej_after", 64'({bus.err, bus.busy, bus.inst}), 64'({1'b0, 1'b0, IdleW}));
  endtask

  // mode: 0 valid tied high, 1 pattern 1,0,0 repeating, 2 random valid.
  task automatic run_tile(input int n, input bit acc, input int mode, input bit hold,
                          input bit abort);
    logic [33:0] w;
    bit v, exp_rd, exp_done, pend, fin;
    int rd, wr;
    bus.num_x = 8'(n); bus.acc_en = acc; bus.start = 1'b1;
    step();
    bus.start = hold; bus.num_x = 8'($urandom); bus.acc_en = 1'($urandom);
    chk("accept", 64'({bus.busy, bus.sfp_reset, bus.err, bus.inst}),
        64'({1'b0, 1'b1, 1'b0, IdleW}));
    build_exp(n, acc);
    foreach (exp_q[i]) begin
      step();
      chk("seq", 64'({bus.psum_ready, bus.busy, bus.sfp_reset, bus.done, bus.err, bus.inst}),
          64'({exp_q[i][34], 1'b1, 1'b0, 1'b0, 1'b0, exp_q[i][33:0]}));
      if (abort && exp_q[i][1]) begin
        abort_reset();
        return;
      end
    end
    bus.start = 1'b0;
    rd = 0; wr = 0; pend = 1'b0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.ofifo_valid = v;
      exp_rd = v && (rd < n);
      step();
      w = IdleW; w[6] = exp_rd; exp_done = 1'b0;
      if (pend) begin
        w[31] = 1'b0; w[32] = 1'b0; w[30:20] = 11'(wr);
        exp_done = (wr == n - 1);
        wr++;
      end
      chk("drain", 64'({bus.done, bus.busy, bus.inst}), 64'({exp_done, 1'b1, w}));
      pend = exp_rd;
      if (exp_rd) rd++;
      fin = exp_done;
    end
    if (!fin) chk("drain_timeout", 64'(0), 64'(1));
    bus.ofifo_valid = 1'b0;
    step();
    chk("post", 64'({bus.busy, bus.done, bus.sfp_reset, bus.inst}),
        64'({1'b0, 1'b0, 1'b1, IdleW}));
  endtask

  initial begin
    int n;
    bit acc;
    reset = 1'b1; bus.start = 1'b0; bus.num_x = '0; bus.acc_en = 1'b0; bus.ofifo_valid = 1'b0;
    repeat (3) step();
    chk("rst", 64'({bus.busy, bus.done, bus.err, bus.psum_ready, bus.sfp_reset, bus.inst}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IdleW}));
    reset = 1'b0;
    step();
    chk("idle", 64'({bus.busy, bus.done, bus.err, bus.psum_ready, bus.sfp_reset, bus.inst}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IdleW}));
    run_tile(4, 1'b0, 0, 1'b0, 1'b0);
    run_tile(8, 1'b1, 0, 1'b0, 1'b0);
    reject(0, 1'b0);
    reject(9, 1'b1);
    run_tile(5, 1'b0, 1, 1'b0, 1'b0);
    run_tile(4, 1'b0, 0, 1'b0, 1'b1);
    run_tile(4, 1'b0, 0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      acc = 1'($urandom_range(0, 1));
      n = acc ? int'($urandom_range(1, Row)) : int'($urandom_range(1, 24));
      run_tile(n, acc, 2, 1'b1, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
